// File: rtl/mul_arbiter_pkg.sv
// Shared FP32 field layout, default exponent bias and operand bundle for the
// shared-multiplier arbiter.
package mul_arbiter_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] BIAS    = 8'd127;
  localparam logic [FP_W-1:0]  FP_ZERO = 32'h0;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } op_pair_t;
endpackage

// File: rtl/Mul.sv
// Combinational FP32 multiplier: truncating mantissa product, a zero exponent
// field is treated as zero, no NaN/Inf or exponent range handling.
module Mul
  import mul_arbiter_pkg::*;
#(
  parameter logic [EXP_W-1:0] BIAS = mul_arbiter_pkg::BIAS
) (
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] p
);
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W:0]       ma, mb;
  logic [2*MAN_W+1:0]   mp;
  logic [EXP_W+1:0]     ep;
  logic [MAN_W-1:0]     man;
  logic                 sgn, zero;
  logic                 unused_bits;

  assign ea   = a[FP_W-2 -: EXP_W];
  assign eb   = b[FP_W-2 -: EXP_W];
  assign ma   = {1'b1, a[MAN_W-1:0]};
  assign mb   = {1'b1, b[MAN_W-1:0]};
  assign sgn  = a[FP_W-1] ^ b[FP_W-1];
  assign zero = (ea == '0) || (eb == '0);
  assign mp   = ma * mb;

  // Product of two 1.x mantissas lies in [1,4); the top bit selects the shift.
  assign ep  = {2'b0, ea} + {2'b0, eb} - {2'b0, BIAS} + {{(EXP_W+1){1'b0}}, mp[2*MAN_W+1]};
  assign man = mp[2*MAN_W+1] ? mp[2*MAN_W -: MAN_W] : mp[2*MAN_W-1 -: MAN_W];

  assign p = zero ? FP_ZERO : {sgn, ep[EXP_W-1:0], man};

  assign unused_bits = ^{ep[EXP_W+1:EXP_W], mp[MAN_W-1:0]};
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding N requesters into one shared FP32 multiplier
// through a two-stage pipeline with output backpressure.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int               N    = 4,
  parameter int               IDW  = 2,
  parameter logic [EXP_W-1:0] BIAS = mul_arbiter_pkg::BIAS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [FP_W*N-1:0]    req_a,
  input  logic [FP_W*N-1:0]    req_b,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [FP_W-1:0]      out_data,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic                 busy
);
  localparam int STAGES = 2;

  logic [N-1:0][FP_W-1:0] a_lane, b_lane;
  logic [STAGES:1]        vld_pipe;
  logic [IDW-1:0]         rr, gnt_id, s1_id;
  logic                   gnt_any, en, hs;
  op_pair_t               s1_op;
  logic [FP_W-1:0]        prod;
  int                     j;

  assign a_lane    = req_a;
  assign b_lane    = req_b;
  assign out_valid = vld_pipe[STAGES];
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign busy      = |vld_pipe;

  // First valid requester at or after rr, wrapping past N-1.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = rr;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr) + k;
      if (j >= N) j = j - N;
      if (!gnt_any && req_valid[j[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && en && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign hs = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rr       <= '0;
      s1_op    <= '0;
      s1_id    <= '0;
      out_data <= FP_ZERO;
      out_id   <= '0;
    end else begin
      if (hs) rr <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
      if (en) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], hs};
        if (hs) begin
          s1_op <= '{a: a_lane[gnt_id], b: b_lane[gnt_id]};
          s1_id <= gnt_id;
        end
        out_data <= prod;
        out_id   <= s1_id;
      end
    end
  end

  Mul #(.BIAS(BIAS)) u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .p (prod)
  );
endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter: an in-order result queue with per-item
// pipeline age and a real-arithmetic FP32 product model.
module tb_mul_arbiter;
  localparam int N = 4;

  logic            clk, rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic            out_valid, out_ready, busy;
  logic [31:0]     out_data;
  logic [1:0]      out_id;

  mul_arbiter #(.N(N), .IDW(2), .BIAS(8'd127)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Value-level product: exact double multiply, then truncate to single.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dp;
    logic [10:0] e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    dp = $realtobits($bitstoreal(da) * $bitstoreal(db));
    e  = dp[62:52] - 11'd896;
    return {dp[63], e[7:0], dp[51:29]};
  endfunction

  function automatic logic [31:0] gen_fp();
    if ($urandom_range(0, 7) == 0) return {1'($urandom), 31'd0};
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Reference: accepted items in order; age 1 = first stage, age 2 = visible.
  typedef struct { logic [31:0] d; logic [1:0] id; int age; } item_t;
  item_t       q[$];
  int          rr_m = 0;
  int          g;
  logic        ev, en_m;
  logic [31:0] exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      q.delete();
      rr_m = 0;
    end else begin
      ev   = (q.size() > 0) && (q[0].age == 2);
      en_m = !ev || out_ready;
      g    = -1;
      if (en_m)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
      exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
      chk("req_ready", 32'(req_ready), exp_rdy);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("out_data", out_data, q[0].d);
        chk("out_id", 32'(out_id), 32'(q[0].id));
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
      if (en_m) begin
        if (ev) void'(q.pop_front());
        foreach (q[i]) if (q[i].age < 2) q[i].age++;
        if (g >= 0) begin
          q.push_back('{d: fp_mul(req_a[32*g +: 32], req_b[32*g +: 32]), id: 2'(g), age: 1});
          rr_m = (g + 1) % N;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone requester 3 with rr=0 wins at once and wraps rr back to 0.
    next_cyc();
    set_req(3, 32'h3FC00000, 32'h40000000);
    req_valid = 4'b1000;
    #1 chk("only_req3", 32'(req_ready), 32'h8);
    next_cyc();
    req_valid = '0;
    repeat (3) next_cyc();

    // All requesters for 8 cycles: strict 0,1,2,3 rotation.
    for (int i = 0; i < N; i++) set_req(i, gen_fp(), gen_fp());
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_order", 32'(req_ready), 32'd1 << (k % 4));
      next_cyc();
    end
    req_valid = '0;
    repeat (3) next_cyc();

    // 1.0 * 2.0 from requester 1, two-cycle latency.
    set_req(1, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0010;
    next_cyc();
    req_valid = '0;
    chk("lat_mid_valid", 32'(out_valid), 32'h0);
    next_cyc();
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_data", out_data, 32'h40000000);
    chk("lat_id", 32'(out_id), 32'h1);
    repeat (2) next_cyc();

    // Zero operand from requester 2.
    set_req(2, 32'h00000000, 32'h40400000);
    req_valid = 4'b0100;
    next_cyc();
    req_valid = '0;
    next_cyc();
    chk("zero_data", out_data, 32'h0);
    chk("zero_id", 32'(out_id), 32'h2);
    repeat (2) next_cyc();

    // Backpressure: pipeline full, consumer stalls for 3 cycles.
    for (int i = 0; i < N; i++) set_req(i, gen_fp(), gen_fp());
    req_valid = 4'b1111;
    repeat (2) next_cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      next_cyc();
    end
    out_ready = 1'b1;
    req_valid = '0;
    repeat (4) next_cyc();

    // Reset with both stages occupied.
    req_valid = 4'b1111;
    repeat (2) next_cyc();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    req_valid = 4'b0110;
    #1 chk("post_rst_grant", 32'(req_ready), 32'h2);
    next_cyc();
    req_valid = '0;
    repeat (4) next_cyc();

    // Random traffic, operands may change before acceptance.
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) set_req(i, gen_fp(), gen_fp());
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 300) begin
        #2 rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
      end else begin
        next_cyc();
      end
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (5) next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the multiplier, 2..8.
REQ-002 Parameter IDW, default 2: requester-index width, equal to clog2(N).
REQ-003 Parameter BIAS, default 8'd127: exponent bias passed to the multiplier instance.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  N  bit i set: requester i presents an operand pair.
REQ-007 req_a  input  32*N  IEEE-754 single operand A; requester i occupies bits [32i+31:32i].
REQ-008 req_b  input  32*N  IEEE-754 single operand B; same packing as req_a.
REQ-009 req_ready  output  N  bit i set: requester i's pair is accepted this cycle; at most one bit set.
REQ-010 out_valid  output  1  result holding register is occupied.
REQ-011 out_data  output  32  single-precision product.
REQ-012 out_id  output  IDW  index of the requester that owns out_data.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 busy  output  1  set when any pipeline stage is occupied.

Function
REQ-015 Two-stage pipeline: stage S1 holds registered operands, tag, and s1_valid; stage S2 holds the registered product, tag, and out_valid.
REQ-016 Pipeline enable en = !out_valid || out_ready; when en=0 all S1/S2 registers hold.
REQ-017 Grant: combinational round-robin over req_valid, starting the search at pointer rr, wrapping from N-1 to 0.
REQ-018 req_ready[g] = en && req_valid[g] for the granted g only; all other bits are 0; req_ready is 0 when no bit of req_valid is set.
REQ-019 A handshake (req_valid[i] && req_ready[i]) loads req_a/req_b slice i and tag i into S1 and sets s1_valid; a cycle with en=1 and no handshake clears s1_valid.
REQ-020 On en=1, S2 loads the multiplier output computed from the S1 operands, plus the S1 tag; out_valid takes the value of s1_valid.
REQ-021 Latency: a result appears on out_valid exactly 2 cycles after its handshake edge when out_ready stays 1; throughput is 1 result per cycle.
REQ-022 rr becomes (g+1) mod N after each handshake with requester g; rr is unchanged otherwise.
REQ-023 Backpressure: while out_valid=1 and out_ready=0, out_data, out_id, and the S1 contents are stable and no request is accepted; no result is lost or duplicated.
REQ-024 The product is bit-exact to the team's FP32 multiplier: a zero magnitude in either operand gives 0x00000000; there is no special NaN or Inf handling.
REQ-025 Results leave in acceptance order; out_id always matches the requester whose operands produced out_data.
REQ-026 Requester-side rule: requester i holds req_valid[i] and its operands stable until req_ready[i]; a change before acceptance is not a protocol violation for this block and simply presents a new request.
REQ-027 busy = s1_valid || out_valid.

Reset
REQ-028 rst_n=0 asynchronously clears s1_valid, out_valid, rr (to 0), out_data (to 0), out_id (to 0), and all S1 operand and tag registers.
REQ-029 Reset mid-operation discards all in-flight results without emitting them; the first grant after release goes to the lowest-index valid requester.
REQ-030 While rst_n=0, req_ready is all zero.

Structure
REQ-031 The shared package holds the FP32 field widths (sign 1, exponent 8, mantissa 23), BIAS, and the zero constant 32'h0.
REQ-032 Exactly one sub-module: the existing combinational FP32 multiplier Mul, instantiated once between S1 and S2; no second multiplier.
REQ-033 The round-robin grant is implemented inline, not as a separate module.

Verification
REQ-034 Requester 1 sends a=0x3F800000, b=0x40000000 with out_ready=1 -> out_valid 2 cycles later, out_data=0x40000000, out_id=1.
REQ-035 All 4 req_valid held high for 8 cycles with out_ready=1 -> grant order 0,1,2,3,0,1,2,3 and 8 results with matching out_id.
REQ-036 out_ready held 0 for 3 cycles while results are pending -> out_data and out_id stable, req_ready=0, and all results delivered afterward in order.
REQ-037 Requester 2 sends a=0x00000000, b=0x40400000 -> out_data=0x00000000, out_id=2.
REQ-038 rst_n pulsed low with S1 and S2 occupied -> out_valid=0 and busy=0 immediately, and no stale result appears after release.
REQ-039 Only requester 3 valid, rr=0 -> requester 3 granted at once; rr becomes 0 (wrap).
